// File: rtl/stream_master_splitter_if.sv
// Entry-side and AXI-Stream master-side signals of stream_master_splitter.
// Optional statistics outputs are present when MASTER_STATS_EN is defined.
interface stream_master_splitter_if #(
    parameter int unsigned T_DATA_WIDTH = 8,
    parameter int unsigned M_KEEP_WIDTH = 4
);
    localparam int unsigned ENTRY_W = (2 + T_DATA_WIDTH) * M_KEEP_WIDTH;
    localparam int unsigned DATA_W  = T_DATA_WIDTH * M_KEEP_WIDTH;

    logic                    entry_valid_i;
    logic                    entry_ready_o;
    logic [ENTRY_W-1:0]      entry_i;
    logic                    m_valid_o;
    logic                    m_ready_i;
    logic                    m_last_o;
    logic [M_KEEP_WIDTH-1:0] m_keep_o;
    logic [DATA_W-1:0]       m_data_o;
`ifdef MASTER_STATS_EN
    logic [31:0]             beat_count_o;
    logic [31:0]             pkt_count_o;
`endif

    modport master (
`ifdef MASTER_STATS_EN
        output beat_count_o,
        output pkt_count_o,
`endif
        input  entry_valid_i,
        input  entry_i,
        input  m_ready_i,
        output entry_ready_o,
        output m_valid_o,
        output m_last_o,
        output m_keep_o,
        output m_data_o
    );

    modport slave (
`ifdef MASTER_STATS_EN
        input  beat_count_o,
        input  pkt_count_o,
`endif
        output entry_valid_i,
        output entry_i,
        output m_ready_i,
        input  entry_ready_o,
        input  m_valid_o,
        input  m_last_o,
        input  m_keep_o,
        input  m_data_o
    );
endinterface

// File: rtl/stream_master_splitter.sv
// Splits packed multi-lane entries at each last marker into registered AXI-Stream beats.
// Define MASTER_STATS_EN to add accepted-beat and packet counters.
module stream_master_splitter #(
    parameter int unsigned T_DATA_WIDTH = 8,
    parameter int unsigned M_KEEP_WIDTH = 4
) (
    input  logic clk,
    input  logic rst,
    stream_master_splitter_if.master bus
);
    localparam int unsigned LANE_W  = 2 + T_DATA_WIDTH;
    localparam int unsigned ENTRY_W = LANE_W * M_KEEP_WIDTH;
    localparam int unsigned DATA_W  = T_DATA_WIDTH * M_KEEP_WIDTH;
    localparam int unsigned PTR_W   = $clog2(M_KEEP_WIDTH);
    localparam logic [PTR_W-1:0] LAST_LANE = PTR_W'(M_KEEP_WIDTH - 1);

    logic [ENTRY_W-1:0]      entry;
    logic [M_KEEP_WIDTH-1:0] lane_keep;
    logic [M_KEEP_WIDTH-1:0] lane_last;
    logic [PTR_W-1:0]        ptr;
    logic [PTR_W-1:0]        seg_end;
    logic [M_KEEP_WIDTH-1:0] seg_keep;
    logic [DATA_W-1:0]       seg_data;
    logic                    seg_last;
    logic                    seg_final;
    logic                    seg_empty;
    logic                    advance;

    assign entry = bus.entry_i;

    // Unpack per-lane keep/last flags
    always_comb begin
        lane_keep = '0;
        lane_last = '0;
        for (int i = 0; i < int'(M_KEEP_WIDTH); i++) begin
            lane_keep[i] = entry[i*LANE_W];
            lane_last[i] = entry[i*LANE_W + 1];
        end
    end

    // Current segment: from ptr up to the first last marker (or the top lane)
    always_comb begin
        logic found;
        found     = 1'b0;
        seg_end   = LAST_LANE;
        seg_keep  = '0;
        seg_data  = '0;
        seg_final = 1'b1;
        for (int i = 0; i < int'(M_KEEP_WIDTH); i++) begin
            if (!found && (PTR_W'(i) >= ptr) && lane_last[i]) begin
                seg_end = PTR_W'(i);
                found   = 1'b1;
            end
        end
        for (int i = 0; i < int'(M_KEEP_WIDTH); i++) begin
            if ((PTR_W'(i) >= ptr) && (PTR_W'(i) <= seg_end)) begin
                seg_keep[i] = lane_keep[i];
                if (lane_keep[i])
                    seg_data[i*T_DATA_WIDTH +: T_DATA_WIDTH] = entry[i*LANE_W + 2 +: T_DATA_WIDTH];
            end
            // Anything meaningful above the segment means more segments remain
            if ((PTR_W'(i) > seg_end) && (lane_keep[i] || lane_last[i]))
                seg_final = 1'b0;
        end
        seg_last  = lane_last[seg_end];
        seg_empty = (seg_keep == '0) && !seg_last;
    end

    assign advance           = bus.entry_valid_i && (!bus.m_valid_o || bus.m_ready_i);
    assign bus.entry_ready_o = advance && seg_final && !rst;

    // Output register and segment pointer
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr           <= '0;
            bus.m_valid_o <= 1'b0;
            bus.m_last_o  <= 1'b0;
            bus.m_keep_o  <= '0;
            bus.m_data_o  <= '0;
        end else if (advance) begin
            ptr <= seg_final ? '0 : PTR_W'(seg_end + 1'b1);
            if (!seg_empty) begin
                bus.m_valid_o <= 1'b1;
                bus.m_last_o  <= seg_last;
                bus.m_keep_o  <= seg_keep;
                bus.m_data_o  <= seg_data;
            end else if (bus.m_ready_i) begin
                bus.m_valid_o <= 1'b0;
            end
        end else if (bus.m_valid_o && bus.m_ready_i) begin
            bus.m_valid_o <= 1'b0;
        end
    end

`ifdef MASTER_STATS_EN
    // Accepted-beat and completed-packet counters, wrapping at 2^32
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.beat_count_o <= '0;
            bus.pkt_count_o  <= '0;
        end else if (bus.m_valid_o && bus.m_ready_i) begin
            bus.beat_count_o <= bus.beat_count_o + 32'd1;
            if (bus.m_last_o)
                bus.pkt_count_o <= bus.pkt_count_o + 32'd1;
        end
    end
`endif
endmodule
